l1_mem_arbiter: RTL

L1_MEM_ARBITER -- requirements
Module: l1_mem_arbiter

---
 rtl/l1_mem_arbiter.sv | 118 +++++++++++
 1 files changed

// File: rtl/l1_mem_arbiter.sv
// l1_mem_arbiter: shares one line-wide memory port between icache fills and dcache fills/writebacks.
// Optional macro ARB_ROUND_ROBIN_EN: alternate grants on contention instead of fixed dcache priority.
`timescale 1ns/1ps
module l1_mem_arbiter #(
  parameter int unsigned LINE_BITS      = 256,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                 CLK,
  input  logic                 RESET,
  input  logic                 ic_req,
  input  logic [31:0]          ic_address,
  output logic [LINE_BITS-1:0] ic_data,
  output logic                 ic_valid,
  input  logic                 dc_req,
  input  logic                 dc_we,
  input  logic [31:0]          dc_address,
  input  logic [LINE_BITS-1:0] dc_wdata,
  output logic [LINE_BITS-1:0] dc_data,
  output logic                 dc_valid,
  output logic                 mem_req,
  output logic                 mem_we,
  output logic [31:0]          mem_address,
  output logic [LINE_BITS-1:0] mem_wdata,
  input  logic [LINE_BITS-1:0] mem_data,
  input  logic                 mem_valid,
  output logic                 timeout_err
);

  localparam int unsigned WAIT_W    = 8;
  localparam logic [31:0] LINE_MASK = 32'hFFFF_FFE0;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t            state;
  logic              grant_dc;
  logic [WAIT_W-1:0] wait_cnt;
  logic              pick_dc_c;

`ifdef ARB_ROUND_ROBIN_EN
  logic last_dc;

  // On contention the requester not served last wins; reset value favours dcache first.
  assign pick_dc_c = dc_req && !(ic_req && last_dc);

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      last_dc <= 1'b0;
    end else if (state == IDLE && (ic_req || dc_req)) begin
      last_dc <= pick_dc_c;
    end
  end
`else
  assign pick_dc_c = dc_req;
`endif

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state       <= IDLE;
      grant_dc    <= 1'b0;
      wait_cnt    <= '0;
      mem_req     <= 1'b0;
      mem_we      <= 1'b0;
      mem_address <= '0;
      mem_wdata   <= '0;
      ic_data     <= '0;
      dc_data     <= '0;
      ic_valid    <= 1'b0;
      dc_valid    <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      ic_valid <= 1'b0;
      dc_valid <= 1'b0;
      unique case (state)
        IDLE: begin
          if (ic_req || dc_req) begin
            grant_dc    <= pick_dc_c;
            mem_req     <= 1'b1;
            mem_we      <= pick_dc_c & dc_we;
            mem_address <= (pick_dc_c ? dc_address : ic_address) & LINE_MASK;
            mem_wdata   <= pick_dc_c ? dc_wdata : '0;
            wait_cnt    <= '0;
            state       <= BUSY;
          end
        end
        BUSY: begin
          if (mem_valid) begin
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
            if (grant_dc) begin
              dc_data  <= mem_data;
              dc_valid <= 1'b1;
            end else begin
              ic_data  <= mem_data;
              ic_valid <= 1'b1;
            end
            state <= DONE;
          end else if (wait_cnt == WAIT_LAST) begin
            // Memory never answered: abandon the transaction without a valid pulse.
            mem_req     <= 1'b0;
            mem_we      <= 1'b0;
            timeout_err <= 1'b1;
            state       <= DONE;
          end else begin
            wait_cnt <= wait_cnt + WAIT_W'(1);
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
